// File: rtl/pipe_de_stage.sv
// ID/EX pipeline register with a valid/ready handshake, an optional skid entry,
// a bubble-inserting flush and per-instruction cancel/PC/delay-slot capture.
module pipe_de_stage #(
  parameter int DW    = 32,
  parameter int RNW   = 5,
  parameter int ALUCW = 4,
  parameter bit SKID  = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic             dwreg,
  input  logic             dm2reg,
  input  logic             dwmem,
  input  logic             daluimm,
  input  logic             dshift,
  input  logic             djal,
  input  logic [ALUCW-1:0] daluc,
  input  logic [DW-1:0]    da,
  input  logic [DW-1:0]    db,
  input  logic [DW-1:0]    dimm,
  input  logic [DW-1:0]    dpc4,
  input  logic [DW-1:0]    dpc,
  input  logic [RNW-1:0]   drn,
  input  logic             dcancel,
  input  logic             dbd,
  input  logic             flush,
  output logic             e_valid,
  input  logic             e_ready,
  output logic             ewreg,
  output logic             em2reg,
  output logic             ewmem,
  output logic             ealuimm,
  output logic             eshift,
  output logic             ejal,
  output logic [ALUCW-1:0] ealuc,
  output logic [DW-1:0]    ea,
  output logic [DW-1:0]    eb,
  output logic [DW-1:0]    eimm,
  output logic [DW-1:0]    epc4,
  output logic [DW-1:0]    epc,
  output logic [RNW-1:0]   ern,
  output logic             ecancel,
  output logic             ebd,
  output logic [1:0]       occ
);

  typedef struct packed {
    logic             wreg;
    logic             m2reg;
    logic             wmem;
    logic             aluimm;
    logic             shift;
    logic             jal;
    logic [ALUCW-1:0] aluc;
    logic [DW-1:0]    a;
    logic [DW-1:0]    b;
    logic [DW-1:0]    imm;
    logic [DW-1:0]    pc4;
    logic [DW-1:0]    pc;
    logic [RNW-1:0]   rn;
    logic             cancel;
    logic             bd;
  } entry_t;

  // Encoding chosen so that bit 1 is exactly "skid entry valid".
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, skid_q, d_entry;
  logic   accept, retire;
  logic   load_main_d, load_main_skid, load_skid;

  // A cancelled instruction keeps its PC and delay-slot flag but loses every side effect.
  always_comb begin
    d_entry        = '0;
    d_entry.wreg   = dwreg & ~dcancel;
    d_entry.m2reg  = dm2reg & ~dcancel;
    d_entry.wmem   = dwmem & ~dcancel;
    d_entry.aluimm = daluimm;
    d_entry.shift  = dshift;
    d_entry.jal    = djal & ~dcancel;
    d_entry.aluc   = daluc;
    d_entry.a      = da;
    d_entry.b      = db;
    d_entry.imm    = dimm;
    d_entry.pc4    = dpc4;
    d_entry.pc     = dpc;
    d_entry.rn     = drn;
    d_entry.cancel = dcancel;
    d_entry.bd     = dbd;
  end

  assign e_valid = (state_q != EMPTY);
  assign d_ready = SKID ? ~state_q[1] : (~e_valid | e_ready);
  assign accept  = d_valid & d_ready;
  assign retire  = e_valid & e_ready;
  assign occ     = state_q;

  always_comb begin
    state_d        = state_q;
    load_main_d    = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            load_main_d = 1'b1;
          end
        end
        ONE: begin
          if (accept && retire) begin
            load_main_d = 1'b1;
          end else if (accept && SKID) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (retire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (retire) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Flush scrubs control bits so a stale entry can never write back later.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_q.wreg   <= 1'b0;
      main_q.m2reg  <= 1'b0;
      main_q.wmem   <= 1'b0;
      main_q.jal    <= 1'b0;
      main_q.cancel <= 1'b0;
      skid_q.wreg   <= 1'b0;
      skid_q.m2reg  <= 1'b0;
      skid_q.wmem   <= 1'b0;
      skid_q.jal    <= 1'b0;
      skid_q.cancel <= 1'b0;
    end else begin
      if (load_main_d)         main_q <= d_entry;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= d_entry;
    end
  end

  assign ewreg   = main_q.wreg & e_valid;
  assign em2reg  = main_q.m2reg & e_valid;
  assign ewmem   = main_q.wmem & e_valid;
  assign ejal    = main_q.jal & e_valid;
  assign ecancel = main_q.cancel & e_valid;
  assign ealuimm = main_q.aluimm;
  assign eshift  = main_q.shift;
  assign ebd     = main_q.bd;
  assign ealuc   = main_q.aluc;
  assign ea      = main_q.a;
  assign eb      = main_q.b;
  assign eimm    = main_q.imm;
  assign epc4    = main_q.pc4;
  assign epc     = main_q.pc;
  assign ern     = main_q.rn;

endmodule

// File: tb/tb_pipe_de_stage.sv
// Bench for pipe_de_stage: one SKID=1 and one SKID=0 instance share the decode-side
// inputs; directed scenarios plus a randomized run against a queue-based model.
module tb_pipe_de_stage;

  localparam int VW = 181;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic        aluimm;
    logic        shift;
    logic        jal;
    logic [3:0]  aluc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [31:0] pc;
    logic [4:0]  rn;
    logic        cancel;
    logic        bd;
  } entry_t;

  logic clk, clr, d_valid, flush, e_ready;
  logic dwreg, dm2reg, dwmem, daluimm, dshift, djal, dcancel, dbd;
  logic [3:0]  daluc;
  logic [31:0] da, db, dimm, dpc4, dpc;
  logic [4:0]  drn;

  logic d_ready_s1, e_valid_s1, ewreg_s1, em2reg_s1, ewmem_s1, ealuimm_s1, eshift_s1, ejal_s1, ecancel_s1, ebd_s1;
  logic [3:0]  ealuc_s1;
  logic [31:0] ea_s1, eb_s1, eimm_s1, epc4_s1, epc_s1;
  logic [4:0]  ern_s1;
  logic [1:0]  occ_s1;

  logic d_ready_s0, e_valid_s0, ewreg_s0, em2reg_s0, ewmem_s0, ealuimm_s0, eshift_s0, ejal_s0, ecancel_s0, ebd_s0;
  logic [3:0]  ealuc_s0;
  logic [31:0] ea_s0, eb_s0, eimm_s0, epc4_s0, epc_s0;
  logic [4:0]  ern_s0;
  logic [1:0]  occ_s0;

  int tests_run = 0;
  int tests_failed = 0;

  entry_t q1[$];
  entry_t q0[$];
  entry_t last1, last0;

  pipe_de_stage #(.DW(32), .RNW(5), .ALUCW(4), .SKID(1'b1)) u1 (
    .clk(clk), .clr(clr), .d_valid(d_valid), .d_ready(d_ready_s1),
    .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .daluimm(daluimm), .dshift(dshift), .djal(djal),
    .daluc(daluc), .da(da), .db(db), .dimm(dimm), .dpc4(dpc4), .dpc(dpc), .drn(drn),
    .dcancel(dcancel), .dbd(dbd), .flush(flush), .e_valid(e_valid_s1), .e_ready(e_ready),
    .ewreg(ewreg_s1), .em2reg(em2reg_s1), .ewmem(ewmem_s1), .ealuimm(ealuimm_s1), .eshift(eshift_s1),
    .ejal(ejal_s1), .ealuc(ealuc_s1), .ea(ea_s1), .eb(eb_s1), .eimm(eimm_s1), .epc4(epc4_s1),
    .epc(epc_s1), .ern(ern_s1), .ecancel(ecancel_s1), .ebd(ebd_s1), .occ(occ_s1)
  );

  pipe_de_stage #(.DW(32), .RNW(5), .ALUCW(4), .SKID(1'b0)) u0 (
    .clk(clk), .clr(clr), .d_valid(d_valid), .d_ready(d_ready_s0),
    .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .daluimm(daluimm), .dshift(dshift), .djal(djal),
    .daluc(daluc), .da(da), .db(db), .dimm(dimm), .dpc4(dpc4), .dpc(dpc), .drn(drn),
    .dcancel(dcancel), .dbd(dbd), .flush(flush), .e_valid(e_valid_s0), .e_ready(e_ready),
    .ewreg(ewreg_s0), .em2reg(em2reg_s0), .ewmem(ewmem_s0), .ealuimm(ealuimm_s0), .eshift(eshift_s0),
    .ejal(ejal_s0), .ealuc(ealuc_s0), .ea(ea_s0), .eb(eb_s0), .eimm(eimm_s0), .epc4(epc4_s0),
    .epc(epc_s0), .ern(ern_s0), .ecancel(ecancel_s0), .ebd(ebd_s0), .occ(occ_s0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] obs1();
    return {e_valid_s1, d_ready_s1, occ_s1, ewreg_s1, em2reg_s1, ewmem_s1, ejal_s1, ecancel_s1,
            ealuimm_s1, eshift_s1, ebd_s1, ealuc_s1, ea_s1, eb_s1, eimm_s1, epc4_s1, epc_s1, ern_s1};
  endfunction

  function automatic logic [VW-1:0] obs0();
    return {e_valid_s0, d_ready_s0, occ_s0, ewreg_s0, em2reg_s0, ewmem_s0, ejal_s0, ecancel_s0,
            ealuimm_s0, eshift_s0, ebd_s0, ealuc_s0, ea_s0, eb_s0, eimm_s0, epc4_s0, epc_s0, ern_s0};
  endfunction

  // What EX should see given the number of held instructions and the oldest one.
  function automatic logic [VW-1:0] expv(input int sz, input entry_t fr, input entry_t lst, input logic rdy);
    if (sz > 0)
      return {1'b1, rdy, 2'(sz), fr.wreg, fr.m2reg, fr.wmem, fr.jal, fr.cancel,
              fr.aluimm, fr.shift, fr.bd, fr.aluc, fr.a, fr.b, fr.imm, fr.pc4, fr.pc, fr.rn};
    return {1'b0, rdy, 2'd0, 5'd0, 3'd0, lst.aluc, lst.a, lst.b, lst.imm, lst.pc4, lst.pc, lst.rn};
  endfunction

  function automatic entry_t mk_entry();
    entry_t e;
    e.wreg   = dwreg && !dcancel;
    e.m2reg  = dm2reg && !dcancel;
    e.wmem   = dwmem && !dcancel;
    e.jal    = djal && !dcancel;
    e.cancel = dcancel;
    e.aluimm = daluimm;
    e.shift  = dshift;
    e.aluc   = daluc;
    e.a      = da;
    e.b      = db;
    e.imm    = dimm;
    e.pc4    = dpc4;
    e.pc     = dpc;
    e.rn     = drn;
    e.bd     = dbd;
    return e;
  endfunction

  task automatic model_edge();
    entry_t d = mk_entry();
    bit acc1 = d_valid && (q1.size() < 2);
    bit ret1 = (q1.size() > 0) && e_ready;
    bit acc0 = d_valid && ((q0.size() == 0) || e_ready);
    bit ret0 = (q0.size() > 0) && e_ready;
    if (flush) q1.delete();
    else begin
      if (ret1) void'(q1.pop_front());
      if (acc1) q1.push_back(d);
    end
    if (flush) q0.delete();
    else begin
      if (ret0) void'(q0.pop_front());
      if (acc0) q0.push_back(d);
    end
    if (q1.size() > 0) last1 = q1[0];
    if (q0.size() > 0) last0 = q0[0];
  endtask

  task automatic model_reset();
    q1.delete();
    q0.delete();
    last1 = '0;
    last0 = '0;
  endtask

  task automatic clear_inputs();
    d_valid = 0; flush = 0; e_ready = 0;
    dwreg = 0; dm2reg = 0; dwmem = 0; daluimm = 0; dshift = 0; djal = 0; dcancel = 0; dbd = 0;
    daluc = '0; da = '0; db = '0; dimm = '0; dpc4 = '0; dpc = '0; drn = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    clear_inputs();
    tick();
    clr = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [VW-1:0] want;
    clr = 1'b1;
    clear_inputs();
    #2;
    want = '0;
    want[VW-2] = 1'b1;
    tests_run++;
    if (obs1() !== want) begin
      tests_failed++;
      $display("[TB] FAIL reset_skid1 got %h want %h", obs1(), want);
    end
    tests_run++;
    if (obs0() !== want) begin
      tests_failed++;
      $display("[TB] FAIL reset_skid0 got %h want %h", obs0(), want);
    end
    tick();
    clr = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    do_reset();
    e_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_valid = 1'b1;
      da = 32'h11 + 32'(i);
      tick();
      tests_run++;
      if ({e_valid_s1, occ_s1, ea_s1, d_ready_s1} !== {1'b1, 2'd1, 32'h11 + 32'(i), 1'b1}) begin
        tests_failed++;
        $display("[TB] FAIL stream_skid1[%0d] got v=%b occ=%0d ea=%h rdy=%b want v=1 occ=1 ea=%h rdy=1",
                 i, e_valid_s1, occ_s1, ea_s1, d_ready_s1, 32'h11 + 32'(i));
      end
      tests_run++;
      if ({e_valid_s0, occ_s0, ea_s0} !== {1'b1, 2'd1, 32'h11 + 32'(i)}) begin
        tests_failed++;
        $display("[TB] FAIL stream_skid0[%0d] got v=%b occ=%0d ea=%h want v=1 occ=1 ea=%h",
                 i, e_valid_s0, occ_s0, ea_s0, 32'h11 + 32'(i));
      end
    end
    d_valid = 1'b0;
    tick();
    tests_run++;
    if ({e_valid_s1, occ_s1, ea_s1} !== {1'b0, 2'd0, 32'h14}) begin
      tests_failed++;
      $display("[TB] FAIL stream_drain got v=%b occ=%0d ea=%h want v=0 occ=0 ea=00000014", e_valid_s1, occ_s1, ea_s1);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    e_ready = 1'b0;
    d_valid = 1'b1;
    da = 32'hA0;
    tick();
    tests_run++;
    if ({e_valid_s1, occ_s1, ea_s1, d_ready_s1} !== {1'b1, 2'd1, 32'hA0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL bp_first got v=%b occ=%0d ea=%h rdy=%b want 1 1 a0 1", e_valid_s1, occ_s1, ea_s1, d_ready_s1);
    end
    da = 32'hA1;
    tick();
    d_valid = 1'b0;
    tests_run++;
    if ({e_valid_s1, occ_s1, ea_s1, d_ready_s1} !== {1'b1, 2'd2, 32'hA0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL bp_full got v=%b occ=%0d ea=%h rdy=%b want 1 2 a0 0", e_valid_s1, occ_s1, ea_s1, d_ready_s1);
    end
    tick();
    tests_run++;
    if ({e_valid_s1, occ_s1, ea_s1, d_ready_s1} !== {1'b1, 2'd2, 32'hA0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL bp_hold got v=%b occ=%0d ea=%h rdy=%b want 1 2 a0 0", e_valid_s1, occ_s1, ea_s1, d_ready_s1);
    end
    e_ready = 1'b1;
    tick();
    tests_run++;
    if ({e_valid_s1, occ_s1, ea_s1, d_ready_s1} !== {1'b1, 2'd1, 32'hA1, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL bp_release got v=%b occ=%0d ea=%h rdy=%b want 1 1 a1 1", e_valid_s1, occ_s1, ea_s1, d_ready_s1);
    end
  endtask

  task automatic test_flush();
    do_reset();
    e_ready = 1'b0;
    d_valid = 1'b1;
    dwreg = 1'b1;
    dwmem = 1'b1;
    da = 32'h1;
    tick();
    da = 32'h2;
    tick();
    tests_run++;
    if (occ_s1 !== 2'd2) begin
      tests_failed++;
      $display("[TB] FAIL flush_setup got occ=%0d want 2", occ_s1);
    end
    flush = 1'b1;
    da = 32'hFF;
    tick();
    tests_run++;
    if ({e_valid_s1, occ_s1, ewreg_s1, ewmem_s1, d_ready_s1} !== {1'b0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL flush_skid1 got v=%b occ=%0d wreg=%b wmem=%b rdy=%b want 0 0 0 0 1",
               e_valid_s1, occ_s1, ewreg_s1, ewmem_s1, d_ready_s1);
    end
    tests_run++;
    if ({e_valid_s0, occ_s0, ewreg_s0, ewmem_s0} !== {1'b0, 2'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL flush_skid0 got v=%b occ=%0d wreg=%b wmem=%b want 0 0 0 0", e_valid_s0, occ_s0, ewreg_s0, ewmem_s0);
    end
    flush = 1'b0;
    d_valid = 1'b0;
    e_ready = 1'b1;
    tick();
    tests_run++;
    if ({e_valid_s1, ea_s1} !== {1'b0, 32'h1}) begin
      tests_failed++;
      $display("[TB] FAIL flush_after got v=%b ea=%h want v=0 ea=00000001", e_valid_s1, ea_s1);
    end
  endtask

  task automatic test_cancel();
    do_reset();
    e_ready = 1'b0;
    d_valid = 1'b1;
    dwreg = 1'b1; dwmem = 1'b1; dm2reg = 1'b1; djal = 1'b1;
    dcancel = 1'b1;
    dpc = 32'h400;
    dbd = 1'b1;
    tick();
    d_valid = 1'b0;
    tests_run++;
    if ({e_valid_s1, ewreg_s1, ewmem_s1, em2reg_s1, ejal_s1, ecancel_s1, epc_s1, ebd_s1} !==
        {1'b1, 4'b0000, 1'b1, 32'h400, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL cancel_skid1 got v=%b ctl=%b%b%b%b can=%b pc=%h bd=%b want 1 0000 1 00000400 1",
               e_valid_s1, ewreg_s1, ewmem_s1, em2reg_s1, ejal_s1, ecancel_s1, epc_s1, ebd_s1);
    end
    tests_run++;
    if ({e_valid_s0, ewreg_s0, ewmem_s0, ecancel_s0, epc_s0, ebd_s0} !== {1'b1, 2'b00, 1'b1, 32'h400, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL cancel_skid0 got v=%b wreg=%b wmem=%b can=%b pc=%h bd=%b want 1 0 0 1 00000400 1",
               e_valid_s0, ewreg_s0, ewmem_s0, ecancel_s0, epc_s0, ebd_s0);
    end
  endtask

  task automatic test_skid0_ready();
    do_reset();
    e_ready = 1'b0;
    d_valid = 1'b1;
    da = 32'h55;
    tick();
    da = 32'h66;
    #1;
    tests_run++;
    if ({e_valid_s0, occ_s0, d_ready_s0} !== {1'b1, 2'd1, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL skid0_stall got v=%b occ=%0d rdy=%b want 1 1 0", e_valid_s0, occ_s0, d_ready_s0);
    end
    e_ready = 1'b1;
    #1;
    tests_run++;
    if (d_ready_s0 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL skid0_ready_comb got %b want 1", d_ready_s0);
    end
    tick();
    tests_run++;
    if ({e_valid_s0, occ_s0, ea_s0} !== {1'b1, 2'd1, 32'h66}) begin
      tests_failed++;
      $display("[TB] FAIL skid0_replace got v=%b occ=%0d ea=%h want 1 1 00000066", e_valid_s0, occ_s0, ea_s0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    e_ready = 1'b0;
    d_valid = 1'b1;
    dwreg = 1'b1;
    da = 32'h7;
    tick();
    da = 32'h8;
    tick();
    d_valid = 1'b0;
    tests_run++;
    if (occ_s1 !== 2'd2) begin
      tests_failed++;
      $display("[TB] FAIL async_setup got occ=%0d want 2", occ_s1);
    end
    @(negedge clk);
    clr = 1'b1;
    #1;
    tests_run++;
    if ({e_valid_s1, occ_s1, ea_s1, ewreg_s1, d_ready_s1, e_valid_s0, ea_s0} !==
        {1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("[TB] FAIL async_reset got v=%b occ=%0d ea=%h wreg=%b rdy=%b v0=%b ea0=%h want 0 0 0 0 1 0 0",
               e_valid_s1, occ_s1, ea_s1, ewreg_s1, d_ready_s1, e_valid_s0, ea_s0);
    end
    tick();
    clr = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic [VW-1:0] o, w;
    entry_t fr;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      d_valid = ($urandom_range(0, 9) < 7);
      e_ready = ($urandom_range(0, 9) < 6);
      flush   = ($urandom_range(0, 19) == 0);
      dcancel = ($urandom_range(0, 4) == 0);
      {dwreg, dm2reg, dwmem, daluimm, dshift, djal, dbd} = 7'($urandom);
      daluc = 4'($urandom);
      da = $urandom; db = $urandom; dimm = $urandom; dpc4 = $urandom; dpc = $urandom;
      drn = 5'($urandom);
      #1;
      o = obs1();
      if (!o[VW-1]) o[171:169] = 3'b000;
      fr = (q1.size() > 0) ? q1[0] : '0;
      w = expv(q1.size(), fr, last1, q1.size() < 2);
      tests_run++;
      if (o !== w) begin
        tests_failed++;
        $display("[TB] FAIL random_skid1[%0d] got %h want %h", i, o, w);
      end
      o = obs0();
      if (!o[VW-1]) o[171:169] = 3'b000;
      fr = (q0.size() > 0) ? q0[0] : '0;
      w = expv(q0.size(), fr, last0, (q0.size() == 0) || e_ready);
      tests_run++;
      if (o !== w) begin
        tests_failed++;
        $display("[TB] FAIL random_skid0[%0d] got %h want %h", i, o, w);
      end
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  initial begin
    clr = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_cancel();
    test_skid0_ready();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
